// File: rtl/ufp_mult_pipe.sv
// ---------------------------------------------------------------------------
// ufp_mult_pipe
// Pipelined unsigned fixed-point multiplier, format INT_BITS.FRAC_BITS for
// both operands and the result, with valid/ready flow control, optional
// round-half-up, overflow flag and a saturating overflow event counter.
//
// Build option:
//   UFP_MULT_SAT_EN  defined   -> overflowed results clamp to all ones
//                    undefined -> overflowed results wrap (upper bits dropped)
//
// Ports:
//   iCLK     clock, rising edge
//   iRST_N   asynchronous active-low reset
//   iValid   operand pair valid
//   oReady   block accepts operands this cycle
//   iA, iB   operands, unsigned INT_BITS.FRAC_BITS
//   oValid   result valid
//   iReady   downstream accepts result
//   oC       result, unsigned INT_BITS.FRAC_BITS
//   oOvf     overflow flag belonging to oC
//   iClrCnt  synchronous clear of oOvfCnt (wins over an increment)
//   oOvfCnt  saturating count of overflowed results accepted downstream
// ---------------------------------------------------------------------------
module ufp_mult_pipe #(
   parameter int INT_BITS  = 1,
   parameter int FRAC_BITS = 8,
   parameter int STAGES    = 2,
   parameter int ROUND     = 0,
   parameter int CNT_W     = 16,
   localparam int W        = INT_BITS + FRAC_BITS
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iValid,
   output logic             oReady,
   input  logic [W-1:0]     iA,
   input  logic [W-1:0]     iB,
   output logic             oValid,
   input  logic             iReady,
   output logic [W-1:0]     oC,
   output logic             oOvf,
   input  logic             iClrCnt,
   output logic [CNT_W-1:0] oOvfCnt
);

   // One extra bit above the 2W product so a rounding carry is never lost.
   localparam int PW = 2*W + 1;
   localparam logic [PW-1:0] RND_ADD = (ROUND != 0) ? (PW'(1) << (FRAC_BITS-1)) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [2*W-1:0]    prod;
   logic [PW-1:0]     prod_rnd;
   logic [PW-1:0]     q_full;
   logic              ovf_next;
   logic [W-1:0]      c_next;
   logic              en;

   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] ovf_q;
   logic [W-1:0]      c_q [STAGES];
   logic [CNT_W-1:0]  cnt_q;

   // Arithmetic sits in front of the first register; iA/iB never reach oC
   // without passing through at least one flop.
   assign prod     = (2*W)'(iA) * (2*W)'(iB);
   assign prod_rnd = {1'b0, prod} + RND_ADD;
   assign q_full   = prod_rnd >> FRAC_BITS;
   assign ovf_next = |q_full[PW-1:W];

`ifdef UFP_MULT_SAT_EN
   assign c_next = ovf_next ? {W{1'b1}} : q_full[W-1:0];
`else
   assign c_next = q_full[W-1:0];
`endif

   // Single global advance: the whole pipe moves or the whole pipe holds.
   assign en     = ~oValid | iReady;
   assign oReady = en;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         vld_q <= '0;
         ovf_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            c_q[i] <= '0;
         end
      end else if (en) begin
         vld_q[0] <= iValid;
         ovf_q[0] <= ovf_next;
         c_q[0]   <= c_next;
         for (int i = 1; i < STAGES; i++) begin
            vld_q[i] <= vld_q[i-1];
            ovf_q[i] <= ovf_q[i-1];
            c_q[i]   <= c_q[i-1];
         end
      end
   end

   assign oValid = vld_q[STAGES-1];
   assign oOvf   = ovf_q[STAGES-1];
   assign oC     = c_q[STAGES-1];

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         cnt_q <= '0;
      end else if (iClrCnt) begin
         cnt_q <= '0;
      end else if (oValid && iReady && oOvf && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign oOvfCnt = cnt_q;

endmodule

// File: tb/tb_ufp_mult_pipe.sv
module tb_ufp_mult_pipe;

   localparam int W = 9;
   localparam int F = 8;
   localparam int STAGES = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // main DUT: defaults (1.8, STAGES=2, truncate, 16-bit counter)
   logic         valid_in, ready_out, valid_out, ready_in, ovf, clr;
   logic [W-1:0] a, b, c;
   logic [15:0]  cnt;

   ufp_mult_pipe dut (
      .iCLK(clk), .iRST_N(rst_n), .iValid(valid_in), .oReady(ready_out),
      .iA(a), .iB(b), .oValid(valid_out), .iReady(ready_in), .oC(c),
      .oOvf(ovf), .iClrCnt(clr), .oOvfCnt(cnt)
   );

   // second DUT: rounding, single stage, 2-bit counter
   logic         r_valid, r_oready, r_ovalid, r_iready, r_ovf, r_clr;
   logic [W-1:0] r_a, r_b, r_c;
   logic [1:0]   r_cnt;

   ufp_mult_pipe #(.STAGES(1), .ROUND(1), .CNT_W(2)) dut_r (
      .iCLK(clk), .iRST_N(rst_n), .iValid(r_valid), .oReady(r_oready),
      .iA(r_a), .iB(r_b), .oValid(r_ovalid), .iReady(r_iready), .oC(r_c),
      .oOvf(r_ovf), .iClrCnt(r_clr), .oOvfCnt(r_cnt)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct { logic [W-1:0] c; logic ovf; } res_t;

   // Reference: plain integer arithmetic on the real-valued product.
   function automatic res_t model(input int unsigned ai, input int unsigned bi, input bit rnd);
      res_t r;
      longint unsigned p, q;
      p = longint'(ai) * longint'(bi);
      if (rnd) p = p + (64'd1 << (F-1));
      q = p >> F;
      r.ovf = (q >= (64'd1 << W));
`ifdef UFP_MULT_SAT_EN
      r.c = r.ovf ? W'((1 << W) - 1) : W'(q);
`else
      r.c = W'(q);
`endif
      return r;
   endfunction

   // scoreboard / monitor for the main DUT
   res_t q_exp[$];
   int   cnt_m = 0;
   int   n_out = 0;
   bit   prev_stall = 0;
   logic [W-1:0] prev_c;

   always @(negedge clk) begin
      res_t e;
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         chk("ovf_cnt", 32'(cnt), 32'(cnt_m));
         if (prev_stall) begin
            chk("stall_valid", 32'(valid_out), 32'd1);
            chk("stall_c", 32'(c), 32'(prev_c));
         end
         if (valid_out && ready_in) begin
            if (q_exp.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = q_exp.pop_front();
               chk("out_c", 32'(c), 32'(e.c));
               chk("out_ovf", 32'(ovf), 32'(e.ovf));
               n_out++;
               if (clr) cnt_m = 0;
               else if (e.ovf && cnt_m < 65535) cnt_m++;
            end
         end else if (clr) begin
            cnt_m = 0;
         end
         prev_stall = valid_out && !ready_in;
         prev_c = c;
         if (valid_in && ready_out) q_exp.push_back(model(a, b, 1'b0));
      end
   end

   typedef struct { logic [W-1:0] a; logic [W-1:0] b; logic [W-1:0] c; logic ovf; } vec_t;
   vec_t tbl[9];

   task automatic send_and_check(input vec_t v);
      int lat;
      @(posedge clk); #1;
      a = v.a; b = v.b; valid_in = 1;
      @(posedge clk); #1;
      valid_in = 0;
      lat = 1;
      while (!valid_out && lat < 10) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("tbl_latency", 32'(lat), 32'(STAGES));
      chk("tbl_c", 32'(c), 32'(v.c));
      chk("tbl_ovf", 32'(ovf), 32'(v.ovf));
   endtask

   task automatic r_one(input logic [W-1:0] ai, input logic [W-1:0] bi, input bit clr_i,
                        input logic [W-1:0] exp_c, input bit exp_ovf, input int exp_cnt);
      @(posedge clk); #1;
      r_a = ai; r_b = bi; r_valid = 1; r_clr = 0;
      @(posedge clk); #1;
      r_valid = 0;
      chk("r_valid", 32'(r_ovalid), 32'd1);
      chk("r_c", 32'(r_c), 32'(exp_c));
      chk("r_ovf", 32'(r_ovf), 32'(exp_ovf));
      r_clr = clr_i;
      @(posedge clk); #1;
      r_clr = 0;
      chk("r_cnt", 32'(r_cnt), 32'(exp_cnt));
   endtask

   initial begin
      int sent;
      int n0;
      int wait_cyc;
      logic [W-1:0] ov_c;

`ifdef UFP_MULT_SAT_EN
      ov_c = 9'h1FF;
      tbl[1] = '{9'h1FF, 9'h1FF, 9'h1FF, 1'b1};
      tbl[4] = '{9'h180, 9'h180, 9'h1FF, 1'b1};
      tbl[8] = '{9'h1FF, 9'h101, 9'h1FF, 1'b1};
`else
      ov_c = 9'h000;
      tbl[1] = '{9'h1FF, 9'h1FF, 9'h1FC, 1'b1};
      tbl[4] = '{9'h180, 9'h180, 9'h040, 1'b1};
      tbl[8] = '{9'h1FF, 9'h101, 9'h000, 1'b1};
`endif
      tbl[0] = '{9'h100, 9'h080, 9'h080, 1'b0};
      tbl[2] = '{9'h001, 9'h080, 9'h000, 1'b0};
      tbl[3] = '{9'h100, 9'h100, 9'h100, 1'b0};
      tbl[5] = '{9'h0FF, 9'h0FF, 9'h0FE, 1'b0};
      tbl[6] = '{9'h000, 9'h1FF, 9'h000, 1'b0};
      tbl[7] = '{9'h1FF, 9'h100, 9'h1FF, 1'b0};

      rst_n = 0;
      valid_in = 0; ready_in = 1; clr = 0; a = '0; b = '0;
      r_valid = 0; r_iready = 1; r_clr = 0; r_a = '0; r_b = '0;

      #12;
      chk("rst_valid", 32'(valid_out), 32'd0);
      chk("rst_c", 32'(c), 32'd0);
      chk("rst_ovf", 32'(ovf), 32'd0);
      chk("rst_cnt", 32'(cnt), 32'd0);
      chk("rst_oready", 32'(ready_out), 32'd1);
      chk("rst_r_valid", 32'(r_ovalid), 32'd0);
      @(negedge clk);
      rst_n = 1;

      // directed vectors, one at a time
      foreach (tbl[i]) send_and_check(tbl[i]);

      // rounding DUT: rounding, carry-induced overflow, counter saturation, clear priority
      r_one(9'h001, 9'h080, 0, 9'h001, 0, 0);
      r_one(9'h108, 9'h1F0, 0, ov_c, 1, 1);
`ifdef UFP_MULT_SAT_EN
      r_one(9'h1FF, 9'h1FF, 0, 9'h1FF, 1, 2);
      r_one(9'h1FF, 9'h1FF, 0, 9'h1FF, 1, 3);
      r_one(9'h1FF, 9'h1FF, 0, 9'h1FF, 1, 3);
      r_one(9'h1FF, 9'h1FF, 1, 9'h1FF, 1, 0);
`else
      r_one(9'h1FF, 9'h1FF, 0, 9'h1FC, 1, 2);
      r_one(9'h1FF, 9'h1FF, 0, 9'h1FC, 1, 3);
      r_one(9'h1FF, 9'h1FF, 0, 9'h1FC, 1, 3);
      r_one(9'h1FF, 9'h1FF, 1, 9'h1FC, 1, 0);
`endif
      r_one(9'h0FF, 9'h0FF, 0, 9'h0FE, 0, 0);

      // backpressure: 8 pairs streamed, 5-cycle downstream stall mid-stream
      n0 = n_out;
      sent = 0;
      for (int cyc = 0; cyc < 30; cyc++) begin
         @(posedge clk); #1;
         ready_in = !(cyc >= 4 && cyc < 9);
         valid_in = (sent < 8);
         a = W'($urandom_range(0, 511));
         b = W'($urandom_range(0, 511));
         @(negedge clk);
         if (valid_in && ready_out) sent++;
         if (valid_out && !ready_in) chk("bp_oready", 32'(ready_out), 32'd0);
      end
      @(posedge clk); #1;
      valid_in = 0; ready_in = 1;
      chk("bp_count", 32'(n_out - n0), 32'd8);

      // reset with two items in flight
      @(posedge clk); #1;
      valid_in = 1; a = 9'h1FF; b = 9'h1FF;
      @(posedge clk); #1;
      a = 9'h100; b = 9'h080;
      @(posedge clk); #1;
      valid_in = 0;
      rst_n = 0;
      #1;
      chk("inrst_valid", 32'(valid_out), 32'd0);
      chk("inrst_cnt", 32'(cnt), 32'd0);
      chk("inrst_c", 32'(c), 32'd0);
      chk("inrst_oready", 32'(ready_out), 32'd1);
      q_exp.delete();
      cnt_m = 0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1;
      for (int i = 0; i < STAGES + 3; i++) begin
         @(negedge clk);
         chk("no_stale", 32'(valid_out), 32'd0);
      end

      // randomized traffic with random backpressure and occasional clears
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(posedge clk); #1;
         valid_in = ($urandom_range(0, 3) != 0);
         ready_in = ($urandom_range(0, 2) != 0);
         clr      = ($urandom_range(0, 49) == 0);
         a = W'($urandom_range(0, 511));
         b = W'($urandom_range(0, 511));
      end
      @(posedge clk); #1;
      valid_in = 0; ready_in = 1; clr = 0;
      wait_cyc = 0;
      while (q_exp.size() != 0 && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      chk("drain", 32'(q_exp.size()), 32'd0);

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
